red_share_decoder: RTL and testbench

- Streaming decoder and checker for redundantly encoded words, the consumer side of the core's REDL/REDH share-replication encoding.
- Takes a 32-bit word holding 2 x 16-bit or 4 x 8-bit shares, some of them complemented, and restores the original value.
- Performs bitwise majority voting where possible and flags detected or corrected faults.
- Tracks fault history in an alarm FSM. Sits between the load/store data path and the fault-response logic.

---
 rtl/red_share_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_red_share_decoder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_share_decoder.sv
// Two-stage decoder/checker for REDL/REDH replicated-share words with fault alarm FSM.
// Define RED_DECODER_CORRECT_EN to enable quad-mode 3-1 majority correction.
module red_share_decoder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ALARM_THRESHOLD = 2,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_corrected,
  output logic                  out_uncorrectable,
  output logic                  alarm,
  input  logic                  alarm_clear,
  output logic [CNT_WIDTH-1:0]  fault_count
);

  localparam int HW       = DATA_WIDTH / 2;
  localparam int BW       = DATA_WIDTH / 4;
  localparam int CONSEC_W = 4;

  typedef enum logic [2:0] {
    MODE_DUAL     = 3'd2,
    MODE_DUAL_CPL = 3'd3,
    MODE_QUAD     = 3'd4,
    MODE_QUAD_ALT = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_OK,
    ST_DEGRADED,
    ST_ALARM
  } state_e;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [2:0]            s1_mode;
  logic                  s1_advance;
  logic [DATA_WIDTH-1:0] norm_data;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s2_uncorr;

  logic [DATA_WIDTH-1:0] vote_data;
  logic                  vote_uncorr;
`ifdef RED_DECODER_CORRECT_EN
  logic                  vote_corr;
  logic                  s2_corr;
  logic [2:0]            ones;
  logic                  tie;
  logic                  minority;
`endif

  state_e                state, state_next;
  logic [CONSEC_W-1:0]   consec, consec_next, consec_inc;
  logic [CNT_WIDTH-1:0]  fcnt, fcnt_next;
  logic                  out_fire;

  // in_ready is gated by reset so nothing is accepted while reset is held.
  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = reset && (!s1_valid || s1_advance);

  // Stage 1 input normalisation: undo complemented shares.
  always_comb begin
    norm_data = in_data;
    case (in_mode)
      MODE_DUAL_CPL: norm_data[DATA_WIDTH-1:HW] = ~in_data[DATA_WIDTH-1:HW];
      MODE_QUAD_ALT: begin
        norm_data[4*BW-1:3*BW] = ~in_data[4*BW-1:3*BW];
        norm_data[2*BW-1:BW]   = ~in_data[2*BW-1:BW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= norm_data;
        s1_mode <= in_mode;
      end
    end
  end

  // Stage 2 voting on normalised shares.
  always_comb begin
    vote_data   = '0;
    vote_uncorr = 1'b0;
`ifdef RED_DECODER_CORRECT_EN
    vote_corr   = 1'b0;
    ones        = '0;
    tie         = 1'b0;
    minority    = 1'b0;
`endif
    case (s1_mode)
      MODE_DUAL, MODE_DUAL_CPL: begin
        vote_data[HW-1:0] = s1_data[HW-1:0];
        vote_uncorr       = s1_data[HW-1:0] != s1_data[DATA_WIDTH-1:HW];
      end
      MODE_QUAD, MODE_QUAD_ALT: begin
`ifdef RED_DECODER_CORRECT_EN
        for (int unsigned i = 0; i < BW; i++) begin
          ones = 3'(s1_data[i]) + 3'(s1_data[BW+i]) + 3'(s1_data[2*BW+i]) + 3'(s1_data[3*BW+i]);
          if (ones == 3'd2) tie = 1'b1;
          if (ones == 3'd1 || ones == 3'd3) minority = 1'b1;
          vote_data[i] = ones >= 3'd3;
        end
        if (tie) begin
          vote_data          = '0;
          vote_data[BW-1:0]  = s1_data[BW-1:0];
          vote_uncorr        = 1'b1;
        end else begin
          vote_corr = minority;
        end
`else
        vote_data[BW-1:0] = s1_data[BW-1:0];
        vote_uncorr = (s1_data[2*BW-1:BW]   != s1_data[BW-1:0]) ||
                      (s1_data[3*BW-1:2*BW] != s1_data[BW-1:0]) ||
                      (s1_data[4*BW-1:3*BW] != s1_data[BW-1:0]);
`endif
      end
      default: vote_uncorr = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_uncorr <= 1'b0;
`ifdef RED_DECODER_CORRECT_EN
      s2_corr   <= 1'b0;
`endif
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= vote_data;
        s2_uncorr <= vote_uncorr;
`ifdef RED_DECODER_CORRECT_EN
        s2_corr   <= vote_corr;
`endif
      end
    end
  end

  assign out_valid         = s2_valid;
  assign out_data          = s2_data;
  assign out_uncorrectable = s2_uncorr;
`ifdef RED_DECODER_CORRECT_EN
  assign out_corrected     = s2_corr;
`else
  assign out_corrected     = 1'b0;
`endif

  assign out_fire   = s2_valid && out_ready;
  assign consec_inc = (consec == '1) ? consec : consec + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= ST_OK;
      consec <= '0;
      fcnt   <= '0;
    end else begin
      state  <= state_next;
      consec <= consec_next;
      fcnt   <= fcnt_next;
    end
  end

  // alarm_clear takes priority over a coincident output handshake.
  always_comb begin
    state_next  = state;
    consec_next = consec;
    fcnt_next   = fcnt;
    if (alarm_clear) begin
      state_next  = ST_OK;
      consec_next = '0;
      fcnt_next   = '0;
    end else if (out_fire) begin
      if (s2_uncorr) begin
        consec_next = consec_inc;
        if (fcnt != '1) fcnt_next = fcnt + 1'b1;
      end else begin
        consec_next = '0;
      end
      if (state == ST_OK && (s2_uncorr || out_corrected)) state_next = ST_DEGRADED;
      if (s2_uncorr && consec_inc >= CONSEC_W'(ALARM_THRESHOLD)) state_next = ST_ALARM;
    end
  end

  assign alarm       = state == ST_ALARM;
  assign fault_count = fcnt;

endmodule

// File: tb/tb_red_share_decoder.sv
// Self-checking bench for red_share_decoder: directed table, corner sequences, random vs. model.
module tb_red_share_decoder;

  localparam int DW     = 32;
  localparam int THRESH = 2;
  localparam int CW     = 8;
  localparam int FC_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [2:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_corrected;
  logic          out_uncorrectable;
  logic          alarm;
  logic          alarm_clear = 1'b0;
  logic [CW-1:0] fault_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  red_share_decoder #(
    .DATA_WIDTH(DW),
    .ALARM_THRESHOLD(THRESH),
    .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable),
    .alarm(alarm),
    .alarm_clear(alarm_clear),
    .fault_count(fault_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
  } res_t;

  res_t        exp_q[$];
  int          m_consec = 0;
  int          m_fc = 0;
  logic        m_alarm = 1'b0;
  bit          seen_reset = 1'b0;
  int          out_cnt = 0;
  logic [31:0] last_data = '0;
  logic        last_corr = 1'b0;
  logic        last_uncorr = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_data = '0;
  logic [1:0]  held_flags = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference decode straight from the share-replication rules.
  function automatic res_t ref_decode(input logic [31:0] d, input logic [2:0] m);
    res_t        r;
    logic [15:0] hi;
    logic [7:0]  sh[4];
`ifdef RED_DECODER_CORRECT_EN
    int          n1;
    logic        tie;
    logic        minority;
    logic [7:0]  maj;
`endif
    r.data = '0; r.corr = 1'b0; r.uncorr = 1'b0;
    if (m == 3'd2 || m == 3'd3) begin
      hi = (m == 3'd3) ? ~d[31:16] : d[31:16];
      r.data = {16'h0, d[15:0]};
      r.uncorr = hi != d[15:0];
    end else if (m == 3'd4 || m == 3'd5) begin
      for (int k = 0; k < 4; k++) begin
        sh[k] = d[8*k +: 8];
        if (m == 3'd5 && (k % 2) == 1) sh[k] = ~sh[k];
      end
`ifdef RED_DECODER_CORRECT_EN
      tie = 1'b0; minority = 1'b0; maj = '0;
      for (int b = 0; b < 8; b++) begin
        n1 = 0;
        for (int k = 0; k < 4; k++) n1 += int'(sh[k][b]);
        if (n1 == 2) tie = 1'b1;
        else begin
          maj[b] = n1 > 2;
          if (n1 != 0 && n1 != 4) minority = 1'b1;
        end
      end
      if (tie) begin r.data = {24'h0, sh[0]}; r.uncorr = 1'b1; end
      else begin r.data = {24'h0, maj}; r.corr = minority; end
`else
      r.data = {24'h0, sh[0]};
      r.uncorr = !(sh[1] == sh[0] && sh[2] == sh[0] && sh[3] == sh[0]);
`endif
    end else begin
      r.uncorr = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] m, input logic [15:0] v);
    case (m)
      3'd2:    return {v, v};
      3'd3:    return {~v, v};
      3'd4:    return {4{v[7:0]}};
      3'd5:    return {~v[7:0], v[7:0], ~v[7:0], v[7:0]};
      default: return {v, ~v};
    endcase
  endfunction

  // Monitor: scoreboard, counter/alarm model, output stability under stall.
  always @(negedge clock) begin
    res_t e;
    if (!reset) begin
      exp_q.delete();
      m_consec = 0; m_fc = 0; m_alarm = 1'b0;
      seen_reset = 1'b1; held = 1'b0;
    end else if (seen_reset) begin
      chk("alarm", {31'b0, alarm}, {31'b0, m_alarm});
      chk("fault_count", {24'b0, fault_count}, m_fc);
      if (held) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_data", out_data, held_data);
        chk("hold_flags", {30'b0, out_corrected, out_uncorrectable}, {30'b0, held_flags});
      end
      held       = out_valid && !out_ready;
      held_data  = out_data;
      held_flags = {out_corrected, out_uncorrectable};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got 0x%08h expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_corrected", {31'b0, out_corrected}, {31'b0, e.corr});
          chk("out_uncorrectable", {31'b0, out_uncorrectable}, {31'b0, e.uncorr});
          last_data = out_data; last_corr = out_corrected; last_uncorr = out_uncorrectable;
          out_cnt++;
          if (!alarm_clear) begin
            if (e.uncorr) begin
              if (m_consec < 15) m_consec++;
              if (m_fc < FC_MAX) m_fc++;
              if (m_consec >= THRESH) m_alarm = 1'b1;
            end else begin
              m_consec = 0;
            end
          end
        end
      end
      if (alarm_clear) begin m_consec = 0; m_fc = 0; m_alarm = 1'b0; end
      if (in_valid && in_ready) exp_q.push_back(ref_decode(in_data, in_mode));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] m);
    bit acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic wait_outputs(input int target);
    for (int c = 0; c < 40 && out_cnt < target; c++) tick();
    if (out_cnt < target) begin
      total++; bad++;
      $display("FAIL output_timeout: got %0d outputs expected %0d", out_cnt, target);
    end
  endtask

  task automatic send_wait(input logic [31:0] d, input logic [2:0] m);
    int n0 = out_cnt;
    send(d, m);
    wait_outputs(n0 + 1);
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] din;
    logic [31:0] dout;
    logic        corr;
    logic        uncorr;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    logic [31:0] bp_words[4];
    int          n0;
    int          k;
    logic [2:0]  rm;
    logic [31:0] rd;
    int          f;

    tbl[0] = '{3'd2, 32'hBEEFBEEF, 32'h0000BEEF, 1'b0, 1'b0};
    tbl[1] = '{3'd3, 32'h4110BEEF, 32'h0000BEEF, 1'b0, 1'b0};
`ifdef RED_DECODER_CORRECT_EN
    tbl[2] = '{3'd4, 32'h5A5A5B5A, 32'h0000005A, 1'b1, 1'b0};
`else
    tbl[2] = '{3'd4, 32'h5A5A5B5A, 32'h0000005A, 1'b0, 1'b1};
`endif
    tbl[3] = '{3'd5, 32'hA55AA55A, 32'h0000005A, 1'b0, 1'b0};
    tbl[4] = '{3'd4, 32'h5A5A5B5B, 32'h0000005B, 1'b0, 1'b1};
    tbl[5] = '{3'd7, 32'h12345678, 32'h00000000, 1'b0, 1'b1};
    tbl[6] = '{3'd2, 32'h1234ABCD, 32'h0000ABCD, 1'b0, 1'b1};
    tbl[7] = '{3'd0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1};
    tbl[8] = '{3'd5, 32'h5AA55AA5, 32'h000000A5, 1'b0, 1'b0};
    tbl[9] = '{3'd4, 32'hC3C3C3C3, 32'h000000C3, 1'b0, 1'b0};
    bp_words[0] = 32'h11111111; bp_words[1] = 32'h22222222;
    bp_words[2] = 32'h33333333; bp_words[3] = 32'h44444444;

    reset = 1'b0;
    tick(); tick();
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_flags", {30'b0, out_corrected, out_uncorrectable}, 32'd0);
    chk("reset_alarm", {31'b0, alarm}, 32'd0);
    chk("reset_fault_count", {24'b0, fault_count}, 32'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Two-cycle latency.
    in_valid = 1'b1; in_data = 32'hBEEFBEEF; in_mode = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("latency_cycle1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("latency_cycle2_valid", {31'b0, out_valid}, 32'd1);
    chk("latency_cycle2_data", out_data, 32'h0000BEEF);
    tick();

    for (int i = 0; i < 10; i++) begin
      n0 = out_cnt;
      send(tbl[i].din, tbl[i].mode);
      wait_outputs(n0 + 1);
      chk($sformatf("vec%0d_data", i), last_data, tbl[i].dout);
      chk($sformatf("vec%0d_corr", i), {31'b0, last_corr}, {31'b0, tbl[i].corr});
      chk($sformatf("vec%0d_uncorr", i), {31'b0, last_uncorr}, {31'b0, tbl[i].uncorr});
    end

    // Alarm threshold sequence.
    alarm_clear = 1'b1; tick(); alarm_clear = 1'b0;
    chk("clear_alarm", {31'b0, alarm}, 32'd0);
    chk("clear_fault_count", {24'b0, fault_count}, 32'd0);
    send_wait(32'h0, 3'd7);
    send_wait(32'hBEEFBEEF, 3'd2);
    send_wait(32'h0, 3'd7);
    tick();
    chk("u_c_u_no_alarm", {31'b0, alarm}, 32'd0);
    chk("u_c_u_fault_count", {24'b0, fault_count}, 32'd2);
    send_wait(32'hBEEFBEEF, 3'd2);
    send_wait(32'h0, 3'd7);
    send_wait(32'h0, 3'd7);
    tick();
    chk("back_to_back_alarm", {31'b0, alarm}, 32'd1);
    chk("back_to_back_fault_count", {24'b0, fault_count}, 32'd4);
    send_wait(32'hBEEFBEEF, 3'd2);
    tick();
    chk("alarm_sticky", {31'b0, alarm}, 32'd1);

    // Clear coinciding with an uncorrectable output handshake.
    out_ready = 1'b0;
    send(32'h0, 3'd7);
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    n0 = out_cnt;
    out_ready = 1'b1; alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
    chk("clear_wins_alarm", {31'b0, alarm}, 32'd0);
    chk("clear_wins_fault_count", {24'b0, fault_count}, 32'd0);
    chk("clear_wins_consumed", out_cnt, n0 + 1);

    // Backpressure: 4 words, consumer stalled for 5 cycles.
    n0 = out_cnt; k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = k < 4;
      if (k < 4) begin in_data = bp_words[k]; in_mode = 3'd4; end
      @(negedge clock);
      if (in_valid && in_ready) k++;
      @(posedge clock);
      #1;
    end
    chk("stall_accepted", k, 2);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_out_data", out_data, 32'h00000011);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      in_valid = 1'b1; in_data = bp_words[k]; in_mode = 3'd4;
      @(negedge clock);
      if (in_ready) k++;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    wait_outputs(n0 + 4);
    chk("bp_last_data", last_data, 32'h00000044);

    // Reset with both stages full.
    send_wait(32'h0, 3'd6);
    send_wait(32'h0, 3'd1);
    tick();
    chk("pre_reset_alarm", {31'b0, alarm}, 32'd1);
    chk("pre_reset_fault_count", {24'b0, fault_count}, 32'd2);
    out_ready = 1'b0;
    send(32'h77777777, 3'd4);
    send(32'h88888888, 3'd4);
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_reset_alarm", {31'b0, alarm}, 32'd0);
    chk("mid_reset_fault_count", {24'b0, fault_count}, 32'd0);
    chk("mid_reset_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) < 8) rm = 3'($urandom_range(2, 5));
      else rm = 3'($urandom_range(0, 7));
      rd = encode(rm, 16'($urandom));
      f = $urandom_range(0, 3);
      if (f >= 2) rd = rd ^ (32'd1 << $urandom_range(0, 31));
      if (f == 3) rd = rd ^ (32'd1 << $urandom_range(0, 31));
      in_data = rd; in_mode = rm;
      out_ready = $urandom_range(0, 3) != 0;
      alarm_clear = $urandom_range(0, 39) == 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; alarm_clear = 1'b0;
    repeat (10) tick();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
